simu_commit_tracer: RTL
=======================

Name: simu_commit_tracer

Overview:
Simulation-only trace collector for the Verilator testbench top, instantiated beside soc_top. Generalises the fixed debug0/debug1 writeback taps to NUM_CMT commit channels. Each cycle it merges all valid commits into one ordered, sequence-numbered stream and buffers them in a FIFO. The C++ bench drains that stream through a valid/ready handshake, so it can apply backpressure without losing ordering.

Parameters:
NUM_CMT, 2, number of commit channels (1..4)
CPU_WIDTH, 32, PC/data width (32 or 64)
DEPTH, 16, FIFO entries; power of two, >= 2*NUM_CMT
SEQ_WIDTH, 32, sequence/commit counter width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cmt_valid  in  NUM_CMT  channel i committed this cycle
cmt_pc  in  NUM_CMT*CPU_WIDTH  packed PCs; channel i at [i*CPU_WIDTH +: CPU_WIDTH]
cmt_rf_wen  in  NUM_CMT  regfile write enable
cmt_rf_wnum  in  NUM_CMT*5  destination register
cmt_rf_wdata  in  NUM_CMT*CPU_WIDTH  write data
trace_valid  out  1  head entry available
trace_ready  in  1  bench accepts head
trace_kind  out  1  0 = commit, 1 = uart byte
trace_chan  out  2  source channel index
trace_pc  out  CPU_WIDTH  entry PC (uart: 0)
trace_rf_wen  out  1
trace_rf_wnum  out  5
trace_rf_wdata  out  CPU_WIDTH  (uart: byte zero-extended)
trace_seq  out  SEQ_WIDTH  global sequence number of the entry
commit_cnt  out  SEQ_WIDTH  total commits accepted into the FIFO
drop_cnt  out  16  entries dropped; saturates at 16'hFFFF
overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset (aresetn == 0 at a posedge): FIFO empty; trace_valid = 0. commit_cnt, drop_cnt, overflow and the internal seq counter = 0. trace_* data outputs = 0. Reset mid-stream discards all buffered entries.
- Enqueue: entries with cmt_valid set are written in ascending channel index within the cycle, into consecutive FIFO slots. Each entry gets seq = seq_counter + its rank among accepted entries. seq_counter then advances by the number accepted.
- Capacity: free = DEPTH - count, using count before this cycle's dequeue; this is deliberately conservative. If k valid entries arrive and k > free:
  - accept only the lowest-index free entries;
  - drop the rest;
  - drop_cnt += dropped;
  - overflow <= 1.
  Dropped entries consume no seq value.
- Latency: an entry written at edge N is visible at the head after edge N if the FIFO was empty. trace_* outputs come directly from the registered FIFO head, so enqueue-to-trace_valid latency is 1 cycle.
- Dequeue: on trace_valid && trace_ready, the head pops at the edge. trace_* must hold steady while trace_valid && !trace_ready.
- Simultaneous enqueue and dequeue are both performed. count_next = count + accepted - popped.
- Pointers are log2(DEPTH)+1 bits. Full = MSBs differ and LSBs equal. Pointer wrap-around is natural modulo.
- commit_cnt increments by accepted kind-0 entries. It wraps modulo 2^SEQ_WIDTH; so does seq.
- An x/unknown cmt_valid never occurs in a correct bench; no handling is required.

Optional Feature:
TRACE_UART_SNOOP_EN
- Defined: adds ports apb_psel, apb_penable, apb_pwrite (1 bit each), apb_paddr[3:0] and apb_pwdata[7:0].
  - A write access phase (psel && penable && pwrite && paddr == 4'h0) enqueues one kind-1 entry: trace_chan = 0, trace_rf_wdata = pwdata.
  - Within the cycle it is ordered after all commit channels, takes the next seq, and obeys the same capacity/drop rule.
  - It does not increment commit_cnt.
- Undefined: the ports are absent and trace_kind is constant 0.

Decomposition:
- Package simu_trace_pkg holds:
  - TRACE_KIND_COMMIT = 1'b0, TRACE_KIND_UART = 1'b1;
  - UART_THR_OFFSET = 4'h0;
  - RF_NUM_W = 5;
  - the entry struct (kind, chan, pc, wen, wnum, wdata, seq) and its width function.
- One sub-module, simu_trace_fifo: a multi-write (up to NUM_CMT+1 per cycle), single-read synchronous FIFO with registered head. It reports count.
- The top handles packing, ranking, seq assignment and counters.

Test Plan:
1. Channel 0 only, pc=0x1c000000, wen=1, wnum=4, wdata=0xdeadbeef, ready=1 -> next cycle trace_valid=1 with those fields, seq=0, commit_cnt=1.
2. Channels 0 and 1 valid in the same cycle (pc 0x100, 0x104) -> two entries in consecutive beats: chan 0 with seq N, then chan 1 with seq N+1.
3. ready=0 with DEPTH=16 and 2 commits/cycle for 9 cycles -> 16 accepted, 2 dropped; drop_cnt=2; overflow=1; seq values contiguous 0..15.
4. FIFO full, ready=1, one commit arrives in the same cycle -> pop occurs, commit dropped (conservative free), drop_cnt+1.
5. Reset asserted with 5 entries buffered -> next cycle trace_valid=0, all counters 0; the first new commit gets seq=0.
6. (TRACE_UART_SNOOP_EN) APB write to paddr 0 with pwdata 0x41, coincident with a channel-0 commit -> commit entry first, then kind=1 entry with wdata=0x41 and seq+1; commit_cnt increments by 1 only.

Source files
------------

// File: rtl/simu_trace_pkg.sv
// Shared types and constants for the simulation commit tracer.
// Optional build macro used by the tracer: TRACE_UART_SNOOP_EN.
package simu_trace_pkg;

    localparam logic       TRACE_KIND_COMMIT = 1'b0;
    localparam logic       TRACE_KIND_UART   = 1'b1;
    localparam logic [3:0] UART_THR_OFFSET   = 4'h0;
    localparam int         RF_NUM_W          = 5;
    localparam int         CHAN_W            = 2;
    localparam int         MAX_XLEN          = 64;
    localparam int         MAX_SEQ_W         = 64;

    // Widest-case entry layout; the hardware stores a narrowed flat copy
    // whose field order matches this struct (kind in the MSB, seq in the LSBs).
    typedef struct packed {
        logic                 kind;
        logic [CHAN_W-1:0]    chan;
        logic [MAX_XLEN-1:0]  pc;
        logic                 wen;
        logic [RF_NUM_W-1:0]  wnum;
        logic [MAX_XLEN-1:0]  wdata;
        logic [MAX_SEQ_W-1:0] seq;
    } trace_entry_t;

    function automatic int entry_width(input int cpu_w, input int seq_w);
        return 1 + CHAN_W + cpu_w + 1 + RF_NUM_W + cpu_w + seq_w;
    endfunction

endpackage

// File: rtl/simu_trace_fifo.sv
// Multi-write, single-read synchronous FIFO; writes land in consecutive
// slots starting at the write pointer, the head is read straight from storage.
module simu_trace_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    parameter  int NWR   = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int NW    = $clog2(NWR + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NW-1:0]         wr_num,
    input  logic [NWR-1:0][W-1:0] wr_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [W-1:0]          head_data,
    output logic [AW:0]           count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // The writer guarantees wr_num never exceeds the free slot count.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NWR; j++) begin
            if (j < int'(wr_num)) begin
                mem[wptr[AW-1:0] + AW'(j)] <= wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(wr_num);
            if (pop && head_valid) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign count      = wptr - rptr;
    assign head_valid = (wptr != rptr);
    assign head_data  = head_valid ? mem[rptr[AW-1:0]] : '0;

endmodule

// File: rtl/simu_commit_tracer.sv
// Merges per-cycle commits into one ordered, sequence-numbered trace stream.
// Define TRACE_UART_SNOOP_EN to also capture UART THR writes from the APB bus.
module simu_commit_tracer
    import simu_trace_pkg::*;
#(
    parameter int NUM_CMT   = 2,
    parameter int CPU_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int SEQ_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_CMT-1:0]           cmt_valid,
    input  logic [NUM_CMT*CPU_WIDTH-1:0] cmt_pc,
    input  logic [NUM_CMT-1:0]           cmt_rf_wen,
    input  logic [NUM_CMT*5-1:0]         cmt_rf_wnum,
    input  logic [NUM_CMT*CPU_WIDTH-1:0] cmt_rf_wdata,
`ifdef TRACE_UART_SNOOP_EN
    input  logic                         apb_psel,
    input  logic                         apb_penable,
    input  logic                         apb_pwrite,
    input  logic [3:0]                   apb_paddr,
    input  logic [7:0]                   apb_pwdata,
`endif
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic                         trace_kind,
    output logic [1:0]                   trace_chan,
    output logic [CPU_WIDTH-1:0]         trace_pc,
    output logic                         trace_rf_wen,
    output logic [4:0]                   trace_rf_wnum,
    output logic [CPU_WIDTH-1:0]         trace_rf_wdata,
    output logic [SEQ_WIDTH-1:0]         trace_seq,
    output logic [SEQ_WIDTH-1:0]         commit_cnt,
    output logic [15:0]                  drop_cnt,
    output logic                         overflow
);

`ifdef TRACE_UART_SNOOP_EN
    localparam int NREQ = NUM_CMT + 1;
`else
    localparam int NREQ = NUM_CMT;
`endif
    localparam int EW = entry_width(CPU_WIDTH, SEQ_WIDTH);
    localparam int BW = EW - SEQ_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(NREQ + 1);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][BW-1:0] req_body;
    logic [NREQ-1:0][EW-1:0] wr_data;
    logic [NW-1:0]           wr_num;
    logic [NW-1:0]           dropped;
    logic [NW-1:0]           accepted_commits;
    logic [AW:0]             count;
    logic [AW:0]             free;
    logic [SEQ_WIDTH-1:0]    seq_cnt;
    logic [16:0]             drop_sum;
    logic                    head_valid;
    logic [EW-1:0]           head_data;

    // Requests in priority order: commit channels ascending, then the UART write.
    always_comb begin
        req_valid = '0;
        req_body  = '0;
        for (int i = 0; i < NUM_CMT; i++) begin
            req_valid[i] = cmt_valid[i];
            req_body[i]  = {TRACE_KIND_COMMIT, CHAN_W'(i),
                            cmt_pc[i*CPU_WIDTH +: CPU_WIDTH],
                            cmt_rf_wen[i],
                            cmt_rf_wnum[i*RF_NUM_W +: RF_NUM_W],
                            cmt_rf_wdata[i*CPU_WIDTH +: CPU_WIDTH]};
        end
`ifdef TRACE_UART_SNOOP_EN
        req_valid[NUM_CMT] = apb_psel && apb_penable && apb_pwrite
                             && (apb_paddr == UART_THR_OFFSET);
        req_body[NUM_CMT]  = {TRACE_KIND_UART, CHAN_W'(0), CPU_WIDTH'(0), 1'b0,
                              RF_NUM_W'(0), CPU_WIDTH'(apb_pwdata)};
`endif
    end

    // Free space ignores this cycle's pop on purpose, so the accept decision
    // never depends on trace_ready.
    assign free = (AW+1)'(DEPTH) - count;

    always_comb begin
        wr_data          = '0;
        wr_num           = '0;
        dropped          = '0;
        accepted_commits = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (int'(wr_num) < int'(free)) begin
                    wr_data[wr_num] = {req_body[i], seq_cnt + SEQ_WIDTH'(wr_num)};
                    if (req_body[i][BW-1] == TRACE_KIND_COMMIT) begin
                        accepted_commits = accepted_commits + NW'(1);
                    end
                    wr_num = wr_num + NW'(1);
                end else begin
                    dropped = dropped + NW'(1);
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(dropped);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            seq_cnt    <= '0;
            commit_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            seq_cnt    <= seq_cnt + SEQ_WIDTH'(wr_num);
            commit_cnt <= commit_cnt + SEQ_WIDTH'(accepted_commits);
            if (dropped != '0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    simu_trace_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .NWR   (NREQ)
    ) u_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .wr_num     (wr_num),
        .wr_data    (wr_data),
        .pop        (trace_ready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (count)
    );

    // Without UART snooping every stored kind bit is TRACE_KIND_COMMIT and an
    // empty head reads as zero, so trace_kind stays 0.
    assign trace_valid = head_valid;
    assign {trace_kind, trace_chan, trace_pc, trace_rf_wen, trace_rf_wnum,
            trace_rf_wdata, trace_seq} = head_data;

endmodule
